// File: rtl/de0_nano_system_cpu_cpu_mul_seq_if.sv
// Request/response handshake bundle between a CPU pipeline and the sequential multiplier.
// The multiplier owns req_ready, rsp_valid and rsp_result; the requester owns the rest.
interface de0_nano_system_cpu_cpu_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/de0_nano_system_cpu_cpu_mul_seq.sv
// Sequential 32x32 multiplier built around an external 16x16 partial-product cell.
// One cell pass gives the low word; a second pass on the high halves gives the high word.
module de0_nano_system_cpu_cpu_mul_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    de0_nano_system_cpu_cpu_mul_seq_if.slave   bus,
    input  logic                               flush,
    output logic [31:0]                        mc_src1,
    output logic [31:0]                        mc_src2,
    output logic                               mc_en,
    input  logic [31:0]                        mc_p1,
    input  logic [31:0]                        mc_p2,
    input  logic [31:0]                        mc_p3
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        CAP1   = 3'd2,
        ISSUE2 = 3'd3,
        CAP2   = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [1:0] LAST_ISSUE = 2'(CELL_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [31:0] r_p1;
    logic [31:0] r_p2;
    logic [31:0] r_p3;
    logic [16:0] r_hi;
    logic        r_midc;
    logic [31:0] r_result;

    logic        w_req_ready;
    logic        w_rsp_valid;
    logic        w_accept;
    logic [32:0] w_mid;
    logic [48:0] w_low;
    logic [31:0] w_hu;
    logic [31:0] w_corr_a;
    logic [31:0] w_corr_b;
    logic [31:0] w_high;

    assign w_accept = bus.req_valid && w_req_ready;

    // Carry out of the middle sum is kept apart and re-added at bit 16 of the high word.
    assign w_mid  = {1'b0, r_p2} + {1'b0, r_p3};
    assign w_low  = {17'h0, r_p1} + {1'b0, w_mid[31:0], 16'h0};
    assign w_hu   = r_p1 + {15'h0, r_hi} + {15'h0, r_midc, 16'h0};

    assign w_corr_a = (r_op[1] && r_a[31]) ? r_b : 32'h0;
    assign w_corr_b = ((r_op == 2'd3) && r_b[31]) ? r_a : 32'h0;
    assign w_high   = w_hu - w_corr_a - w_corr_b;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        mc_en        = 1'b0;
        mc_src1      = r_a;
        mc_src2      = r_b;

        case (r_state)
            IDLE: begin
                w_req_ready = !flush;
                if (w_accept) begin
                    w_state_next = ISSUE1;
                    w_cnt_next   = 2'd0;
                end
            end
            ISSUE1: begin
                mc_en = 1'b1;
                if (r_cnt == LAST_ISSUE) begin
                    w_state_next = CAP1;
                    w_cnt_next   = 2'd0;
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                end
            end
            // CAP states take two cycles: register the cell outputs, then add.
            CAP1: begin
                if (r_cnt == 2'd0) begin
                    w_cnt_next = 2'd1;
                end else begin
                    w_cnt_next   = 2'd0;
                    w_state_next = (r_op == 2'd0) ? RESP : ISSUE2;
                end
            end
            ISSUE2: begin
                mc_en   = 1'b1;
                mc_src1 = {16'h0, r_a[31:16]};
                mc_src2 = {16'h0, r_b[31:16]};
                if (r_cnt == LAST_ISSUE) begin
                    w_state_next = CAP2;
                    w_cnt_next   = 2'd0;
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                end
            end
            CAP2: begin
                if (r_cnt == 2'd0) begin
                    w_cnt_next = 2'd1;
                end else begin
                    w_cnt_next   = 2'd0;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase

        if (flush) begin
            w_state_next = IDLE;
            w_cnt_next   = 2'd0;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_result = r_result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 2'd0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_op     <= 2'd0;
            r_p1     <= 32'h0;
            r_p2     <= 32'h0;
            r_p3     <= 32'h0;
            r_hi     <= 17'h0;
            r_midc   <= 1'b0;
            r_result <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;

            if (w_accept) begin
                r_a  <= bus.req_a;
                r_b  <= bus.req_b;
                r_op <= bus.req_op;
            end

            // A flushed operation must leave rsp_result untouched.
            if (!flush) begin
                if (((r_state == CAP1) || (r_state == CAP2)) && (r_cnt == 2'd0)) begin
                    r_p1 <= mc_p1;
                    r_p2 <= mc_p2;
                    r_p3 <= mc_p3;
                end
                if ((r_state == CAP1) && (r_cnt == 2'd1)) begin
                    r_hi   <= w_low[48:32];
                    r_midc <= w_mid[32];
                    if (r_op == 2'd0) begin
                        r_result <= w_low[31:0];
                    end
                end
                if ((r_state == CAP2) && (r_cnt == 2'd1)) begin
                    r_result <= w_high;
                end
            end
        end
    end

endmodule
